// File: rtl/screen_pkg.sv
// Screen geometry and pixel/address types shared by the paint framebuffer
// read and write paths.
package screen_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int CELL_SHIFT = 4;
    localparam int COLS       = 40;
    localparam int ROWS       = 30;

    typedef logic [23:0] rgb_t;        // {R,G,B}
    typedef logic [10:0] cell_addr_t;  // cy*COLS + cx

endpackage

// File: rtl/blink_timer.sv
// Counts start-of-frame pixels and toggles the cursor blink phase every
// BLINK_FRAMES frames.
module blink_timer #(
    parameter int BLINK_FRAMES = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pixel_en_i,
    input  logic [10:0] x_i,
    input  logic [10:0] y_i,
    output logic        blink_on_o
);

    localparam logic [5:0] LAST_FRAME = 6'(BLINK_FRAMES - 1);

    logic [5:0] frame_cnt_q, frame_cnt_d;
    logic       blink_q, blink_d;
    logic       sof;

    // Every (0,0) strobe counts, even if repeated back to back.
    assign sof = pixel_en_i && (x_i == 11'd0) && (y_i == 11'd0);

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (sof) begin
            if (frame_cnt_q == LAST_FRAME) begin
                frame_cnt_d = 6'd0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            frame_cnt_q <= 6'd0;
            blink_q     <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign blink_on_o = blink_q;

endmodule

// File: rtl/frame_reader.sv
// Framebuffer read pipeline: pixel coordinate -> cell read -> RGB, with a
// blinking inverted outline drawn around the cursor cell.
module frame_reader #(
    parameter int CELL_SHIFT   = screen_pkg::CELL_SHIFT,
    parameter int COLS         = screen_pkg::COLS,
    parameter int ROWS         = screen_pkg::ROWS,
    parameter int BLINK_FRAMES = 32
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        pixel_en,
    input  logic [10:0] x_coord,
    input  logic [10:0] y_coord,
    input  logic [10:0] cursor_x,
    input  logic [10:0] cursor_y,
    output logic        rd_en,
    output logic [10:0] rd_addr,
    input  logic [23:0] rd_data,
    output logic [7:0]  top_R,
    output logic [7:0]  top_G,
    output logic [7:0]  top_B,
    output logic        out_valid
);

    import screen_pkg::*;

    localparam logic [11:0] CELL_LAST = 12'((1 << CELL_SHIFT) - 1);

    logic       blink_on;
    logic [10:0] cx, cy;
    logic        visible;
    logic        in_square;
    logic        on_edge;
    logic        border;
    cell_addr_t  addr_calc;

    logic        s0_valid_q, s0_vis_q, s0_border_q;
    cell_addr_t  rd_addr_q;
    logic        s1_valid_q, s1_vis_q, s1_inv_q;
    rgb_t        rgb_q;
    logic        out_valid_q;

    blink_timer #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .clk_i      (CLOCK_50),
        .rst_i      (reset),
        .pixel_en_i (pixel_en),
        .x_i        (x_coord),
        .y_i        (y_coord),
        .blink_on_o (blink_on)
    );

    assign cx = x_coord >> CELL_SHIFT;
    assign cy = y_coord >> CELL_SHIFT;

    // The grid check only matters if the cell grid is configured smaller
    // than the screen; it keeps reads inside the buffer.
    assign visible = (x_coord < 11'(H_ACTIVE)) && (y_coord < 11'(V_ACTIVE)) &&
                     (cx < 11'(COLS)) && (cy < 11'(ROWS));

    assign addr_calc = cell_addr_t'(cy * 11'(COLS)) + cx;

    // 12-bit compares so a cursor near the right/bottom edge cannot wrap.
    assign in_square = ({1'b0, x_coord} >= {1'b0, cursor_x}) &&
                       ({1'b0, x_coord} <= ({1'b0, cursor_x} + CELL_LAST)) &&
                       ({1'b0, y_coord} >= {1'b0, cursor_y}) &&
                       ({1'b0, y_coord} <= ({1'b0, cursor_y} + CELL_LAST));

    assign on_edge = (x_coord[CELL_SHIFT-1:0] == '0) || (&x_coord[CELL_SHIFT-1:0]) ||
                     (y_coord[CELL_SHIFT-1:0] == '0) || (&y_coord[CELL_SHIFT-1:0]);

    assign border = in_square && on_edge;

    // Valids advance every cycle; data registers only load behind a valid.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            s0_valid_q  <= 1'b0;
            s0_vis_q    <= 1'b0;
            s0_border_q <= 1'b0;
            rd_addr_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_vis_q    <= 1'b0;
            s1_inv_q    <= 1'b0;
            rgb_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            s0_valid_q  <= pixel_en;
            s1_valid_q  <= s0_valid_q;
            out_valid_q <= s1_valid_q;

            if (pixel_en) begin
                s0_vis_q    <= visible;
                s0_border_q <= border;
                if (visible) begin
                    rd_addr_q <= addr_calc;
                end
            end

            // Blink is sampled here, one cycle after a start-of-frame update,
            // so the whole frame including its first pixel shares one phase.
            if (s0_valid_q) begin
                s1_vis_q <= s0_vis_q;
                s1_inv_q <= s0_border_q && blink_on;
            end

            if (s1_valid_q) begin
                if (!s1_vis_q) begin
                    rgb_q <= '0;
                end else if (s1_inv_q) begin
                    rgb_q <= ~rd_data;
                end else begin
                    rgb_q <= rd_data;
                end
            end
        end
    end

    assign rd_en     = s0_valid_q && s0_vis_q;
    assign rd_addr   = rd_addr_q;
    assign top_R     = rgb_q[23:16];
    assign top_G     = rgb_q[15:8];
    assign top_B     = rgb_q[7:0];
    assign out_valid = out_valid_q;

endmodule
